// File: rtl/cache_arbiter_pkg.sv
// Shared types and defaults for the L1-to-L2 line-interface arbiter.
// Pure declarations: no logic and no latency.
// No backpressure; this package carries no handshake of its own.
package cache_arb_pkg;

  localparam int LINE_WIDTH_DEFAULT = 256;
  localparam int ADDR_WIDTH_DEFAULT = 32;

  // Which L1 side currently owns the downstream port.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  // Side that won the most recent grant; the round-robin pointer.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage : cache_arb_pkg

// File: rtl/cache_arbiter.sv
// Shares one line interface between I-cache misses and D-cache misses/writebacks.
// Latency: grant 1 cycle after the request is seen idle; responses pass through in 0 cycles.
// Backpressure: requesters hold until resp; one idle cycle separates consecutive grants.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int LINE_WIDTH = LINE_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // I-cache side
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  // D-cache side
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  // Downstream (eviction buffer upstream port)
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  grant_t     r_last_grant;
  grant_t     w_next_grant;
  logic       w_pend_i;
  logic       w_pend_d;

  // A D-side write and read are one request; either strobe makes D pending.
  assign w_pend_i = i_read;
  assign w_pend_d = d_read | d_write;

  // Read data is broadcast to both sides; only the resp strobe tells who owns it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // State and round-robin pointer; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= GRANT_I;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_grant;
    end
  end

  // Grant only from idle; a serve state is left solely on mem_resp, so a
  // requester dropping early cannot hand the port to the other side.
  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_last_grant;
    case (r_state)
      ARB_IDLE: begin
        if (w_pend_i && w_pend_d) begin
          w_next_grant = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
          w_next_state = (r_last_grant == GRANT_I) ? ARB_SERVE_D : ARB_SERVE_I;
        end else if (w_pend_i) begin
          w_next_grant = GRANT_I;
          w_next_state = ARB_SERVE_I;
        end else if (w_pend_d) begin
          w_next_grant = GRANT_D;
          w_next_state = ARB_SERVE_D;
        end
      end
      ARB_SERVE_I,
      ARB_SERVE_D: begin
        if (mem_resp) begin
          w_next_state = ARB_IDLE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  // Downstream mux: only the owner's strobes/address/data are visible, and
  // mem_resp is steered to the owner alone (a stray resp in idle goes nowhere).
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (r_state)
      ARB_SERVE_I: begin
        mem_read = i_read;
        mem_addr = i_addr;
        i_resp   = mem_resp;
      end
      ARB_SERVE_D: begin
        // Read+write together is treated as a writeback.
        mem_read  = d_read & ~d_write;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_resp    = mem_resp;
      end
      default: ;
    endcase
  end

endmodule : cache_arbiter

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single L2-side line interface (the eviction buffer's upstream port) between the I-cache miss path and the D-cache miss/writeback path.
- Grants one requester at a time; round-robin on conflict.
- Drives the granted request downstream and routes the response back.
- Sits between the two L1 caches and eviction_buffer.

Parameters:
ADDR_WIDTH, 32, address width of all ports
LINE_WIDTH, 256, cache line width in bits

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
i_read  in  1  I-cache line read request, held until i_resp
i_addr  in  ADDR_WIDTH  I-cache line address
i_rdata  out  LINE_WIDTH  line returned to I-cache
i_resp  out  1  I-cache request complete
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache line write (eviction), held until d_resp
d_addr  in  ADDR_WIDTH  D-cache line address
d_wdata  in  LINE_WIDTH  D-cache write line
d_rdata  out  LINE_WIDTH  line returned to D-cache
d_resp  out  1  D-cache request complete
mem_read  out  1  downstream read strobe
mem_write  out  1  downstream write strobe
mem_addr  out  ADDR_WIDTH  downstream address
mem_wdata  out  LINE_WIDTH  downstream write data
mem_rdata  in  LINE_WIDTH  downstream read data
mem_resp  in  1  downstream completion, single-cycle pulse

Behaviour:
- Reset and clocking: one clock, clk; reset rst_n asynchronous, active-low.
- Reset values:
  - state = ARB_IDLE, last_grant = I.
  - mem_read, mem_write, i_resp, d_resp all 0.
  - mem_addr, mem_wdata = 0.
  - i_rdata and d_rdata are always mem_rdata, combinational and ungated.
- ARB_IDLE:
  - All downstream strobes are 0; mem_addr and mem_wdata are 0.
  - Pending: I = i_read; D = d_read | d_write.
  - Only I pending -> ARB_SERVE_I.
  - Only D pending -> ARB_SERVE_D.
  - Both pending -> grant the side not equal to last_grant (round-robin). After reset, the first conflict grants D.
  - Neither pending -> stay in ARB_IDLE.
  - last_grant updates on the grant edge.
- ARB_SERVE_I:
  - mem_read = i_read, mem_write = 0, mem_addr = i_addr, mem_wdata = 0.
  - i_resp = mem_resp (combinational); d_resp = 0.
  - mem_resp -> ARB_IDLE.
- ARB_SERVE_D:
  - mem_read = d_read & ~d_write, mem_write = d_write.
  - mem_addr = d_addr, mem_wdata = d_wdata.
  - d_resp = mem_resp; i_resp = 0.
  - mem_resp -> ARB_IDLE.
- Latency:
  - A request sampled in ARB_IDLE at edge N appears downstream in cycle N+1.
  - Response passthrough adds 0 cycles.
  - One mandatory ARB_IDLE cycle follows every mem_resp, so a requester's stale held request is never re-granted. Minimum spacing between back-to-back grants is therefore 1 idle cycle.
- Boundary conditions:
  - d_read and d_write both high: treated as a write; mem_read = 0.
  - Granted requester drops its request before mem_resp (protocol violation): stay in the serve state with strobes following the inputs (0). No grant switch until mem_resp.
  - mem_resp while in ARB_IDLE: ignored; no resp pulse to either side.
  - Non-granted requester is never given resp, and its address/data never reach downstream.
  - rst_n asserted mid-transaction: immediate return to ARB_IDLE with all strobes 0. The in-flight transaction is abandoned; the downstream block is reset by the same rst_n.
  - Addresses and data pass unchanged; no alignment checking.

Decomposition:
- Package cache_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
  - grant_t enum {GRANT_I, GRANT_D}.
  - Constants LINE_WIDTH_DEFAULT = 256, ADDR_WIDTH_DEFAULT = 32.
- Single module; no sub-module is natural. The FSM and output muxes are one always_ff plus one always_comb.

Test Plan:
- I only: i_read = 1, i_addr = 0x0000_1000 at cycle 0.
  - Required: mem_read = 1 and mem_addr = 0x0000_1000 from cycle 1.
  - mem_resp with mem_rdata = {8{32'hDEAD_BEEF}} at cycle 4 -> i_resp = 1 and i_rdata equal to that value in cycle 4; d_resp = 0.
  - Cycle 5: ARB_IDLE with all strobes 0.
- D write: d_write = 1, d_addr = 0x0000_2040, d_wdata = {8{32'h1234_5678}}.
  - Required: mem_write = 1 with matching addr/data in cycle 1; mem_read = 0.
  - d_resp pulses with mem_resp.
- Conflict after reset: i_read and d_read both asserted at cycle 0.
  - Required: D granted first.
  - After D's mem_resp and the idle cycle, I granted with mem_addr = i_addr.
  - A second simultaneous conflict then grants D again (alternation).
- Both d_read and d_write high, d_addr = 0x0000_3000.
  - Required: mem_write = 1, mem_read = 0.
- Stray mem_resp in ARB_IDLE with no requests -> i_resp = d_resp = 0, state stays ARB_IDLE.
- rst_n pulled low asynchronously during ARB_SERVE_D, mid-cycle.
  - Required: mem_write drops to 0 before the next clk edge; state is ARB_IDLE after release.
  - The next conflict grants D (last_grant reset to I).
